// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM plus IO window (TX FIFO, RX byte) behind the
// memory controller RAM port. Optional feature macro: RAM_IO_SIM_END_EN.
//
// Ports:
//   clk_in, rst_in        clock, async active-high reset
//   rdy_in                global ready; low freezes the request side
//   rw_flag_in            1 = write, 0 = read
//   addr_in, data_in      byte address / write byte
//   data_out              registered read byte
//   io_buffer_full        registered TX FIFO nearly-full flag
//   tx_data, tx_valid     TX FIFO head towards the UART
//   tx_ready              UART accepts the head byte
//   rx_data, rx_valid     UART receive byte
//   rx_pop                one-cycle pulse: rx_data consumed
//   tx_overflow           sticky: IO write dropped on a full FIFO
//   sim_end               sticky end-of-program flag (0x30004)

module ram_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 8,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rw_flag_in,
  input  logic [31:0] addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        tx_overflow,
  output logic        sim_end
);

  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE =
    PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL =
    CNT_W'(TX_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_HIGH =
    CNT_W'(TX_FIFO_DEPTH - FULL_MARGIN);

  // ------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------
  logic                      is_io;
  logic                      io_tx;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      unused_addr;

  assign is_io    = addr_in[17:16] == 2'b11;
  assign io_tx    = is_io && (addr_in[15:0] == 16'h0000);
  // 0x20000-0x2FFFF fold onto RAM through the low bits.
  assign ram_addr = addr_in[RAM_ADDR_WIDTH-1:0];

  assign unused_addr = ^addr_in[31:18];

  // ------------------------------------------------------------
  // RAM (contents are never reset)
  // ------------------------------------------------------------
  logic [7:0] mem [2**RAM_ADDR_WIDTH];
  logic       ram_we;
  logic [7:0] ram_rd_data;

  assign ram_we      = rdy_in && !is_io && rw_flag_in;
  assign ram_rd_data = mem[ram_addr];

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      mem[ram_addr] <= data_in;
    end
  end

  // ------------------------------------------------------------
  // TX FIFO
  // ------------------------------------------------------------
  logic [7:0]       tx_buf_q [TX_FIFO_DEPTH];
  logic [7:0]       tx_buf_d [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;

  logic push_req;
  logic push;
  logic pop;
  logic at_full;

  assign push_req = rdy_in && io_tx && rw_flag_in;
  assign pop      = (cnt_q != '0) && tx_ready;
  assign at_full  = cnt_q == CNT_FULL;
  // A pop in the same edge frees the slot, so a push at full still lands.
  assign push     = push_req && (!at_full || pop);

  always_comb begin
    tx_buf_d = tx_buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (push) begin
      tx_buf_d[wr_ptr_q] = data_in;
      wr_ptr_d           = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    if (push_req && !push) begin
      ovf_d = 1'b1;
    end

    full_d = cnt_d >= CNT_HIGH;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < TX_FIFO_DEPTH; i++) begin
        tx_buf_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      tx_buf_q <= tx_buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx_data        = tx_buf_q[rd_ptr_q];
  assign tx_valid       = cnt_q != '0;
  assign io_buffer_full = full_q;
  assign tx_overflow    = ovf_q;

  // ------------------------------------------------------------
  // sim_end register
  // ------------------------------------------------------------
  logic sim_end_q;

`ifdef RAM_IO_SIM_END_EN
  logic io_se;
  logic sim_end_d;

  assign io_se = is_io && (addr_in[15:0] == 16'h0004);

  always_comb begin
    sim_end_d = sim_end_q;
    if (rdy_in && io_se && rw_flag_in) begin
      sim_end_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sim_end_q <= 1'b0;
    end else begin
      sim_end_q <= sim_end_d;
    end
  end
`else
  assign sim_end_q = 1'b0;
`endif

  assign sim_end = sim_end_q;

  // ------------------------------------------------------------
  // Read data path
  // ------------------------------------------------------------
  logic [7:0] data_out_q, data_out_d;
  logic       rx_pop_q, rx_pop_d;

  always_comb begin
    data_out_d = data_out_q;
    rx_pop_d   = 1'b0;

    if (rdy_in && !rw_flag_in) begin
      unique case (1'b1)
        !is_io: begin
          data_out_d = ram_rd_data;
        end
        io_tx: begin
          data_out_d = rx_valid ? rx_data : 8'h00;
          rx_pop_d   = rx_valid;
        end
`ifdef RAM_IO_SIM_END_EN
        io_se: begin
          data_out_d = {7'b0, sim_end_q};
        end
`endif
        default: begin
          data_out_d = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_out_q <= 8'h00;
      rx_pop_q   <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rx_pop_q   <= rx_pop_d;
    end
  end

  assign data_out = data_out_q;
  assign rx_pop   = rx_pop_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed stimulus, queue/array reference model,
// per-cycle compare on the falling edge plus literal expectations.

module tb_ram_io_responder;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

`ifdef RAM_IO_SIM_END_EN
  localparam bit SE_EN = 1'b1;
`else
  localparam bit SE_EN = 1'b0;
`endif

  logic        clk_in     = 1'b0;
  logic        rst_in     = 1'b1;
  logic        rdy_in     = 1'b0;
  logic        rw_flag_in = 1'b0;
  logic [31:0] addr_in    = 32'h0;
  logic [7:0]  data_in    = 8'h00;
  logic [7:0]  data_out;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready   = 1'b0;
  logic [7:0]  rx_data    = 8'h00;
  logic        rx_valid   = 1'b0;
  logic        rx_pop;
  logic        tx_overflow;
  logic        sim_end;

  int checks = 0;
  int errors = 0;

  ram_io_responder #(
    .RAM_ADDR_WIDTH(17),
    .TX_FIFO_DEPTH (DEPTH),
    .FULL_MARGIN   (MARGIN)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .rw_flag_in    (rw_flag_in),
    .addr_in       (addr_in),
    .data_in       (data_in),
    .data_out      (data_out),
    .io_buffer_full(io_buffer_full),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_pop        (rx_pop),
    .tx_overflow   (tx_overflow),
    .sim_end       (sim_end)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk8(input string name,
                      input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h",
               name, act, exp);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b",
               name, act, exp);
    end
  endtask

  // ------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------
  logic [7:0] m_mem [logic [16:0]];
  logic [7:0] m_q [$];
  logic [7:0] e_dout = 8'h00;
  bit         e_dk   = 1'b1;
  bit         e_pop  = 1'b0;
  bit         e_ovf  = 1'b0;
  bit         e_se   = 1'b0;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_q.delete();
      e_dout = 8'h00;
      e_dk   = 1'b1;
      e_pop  = 1'b0;
      e_ovf  = 1'b0;
      e_se   = 1'b0;
    end else begin : step
      bit        do_pop;
      bit        do_push;
      bit        io;
      bit        n_se;
      bit [15:0] off;
      do_pop  = (m_q.size() != 0) && tx_ready;
      do_push = 1'b0;
      io      = addr_in[17:16] == 2'b11;
      off     = addr_in[15:0];
      n_se    = e_se;
      e_pop   = 1'b0;
      if (rdy_in) begin
        if (!io) begin
          if (rw_flag_in) begin
            m_mem[addr_in[16:0]] = data_in;
          end else if (m_mem.exists(addr_in[16:0])) begin
            e_dout = m_mem[addr_in[16:0]];
            e_dk   = 1'b1;
          end else begin
            e_dk = 1'b0;
          end
        end else if (off == 16'h0000) begin
          if (rw_flag_in) begin
            do_push = 1'b1;
          end else begin
            e_dout = rx_valid ? rx_data : 8'h00;
            e_pop  = rx_valid;
          end
        end else if (off == 16'h0004 && SE_EN) begin
          if (rw_flag_in) n_se = 1'b1;
          else e_dout = {7'b0, e_se};
        end else if (!rw_flag_in) begin
          e_dout = 8'h00;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(data_in);
        else e_ovf = 1'b1;
      end
      e_se = n_se;
    end
  end

  // ------------------------------------------------------------
  // Per-cycle compare
  // ------------------------------------------------------------
  always @(negedge clk_in) begin
    if (!rst_in) begin
      chk1("tx_valid", tx_valid, m_q.size() != 0);
      chk1("io_buffer_full", io_buffer_full,
           m_q.size() >= DEPTH - MARGIN);
      chk1("tx_overflow", tx_overflow, e_ovf);
      chk1("rx_pop", rx_pop, e_pop);
      chk1("sim_end", sim_end, e_se);
      if (m_q.size() != 0) chk8("tx_data", tx_data, m_q[0]);
      if (e_dk) chk8("data_out", data_out, e_dout);
    end
  end

  // ------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------
  task automatic req(input bit rw,
                     input logic [31:0] a,
                     input logic [7:0] d);
    rdy_in     = 1'b1;
    rw_flag_in = rw;
    addr_in    = a;
    data_in    = d;
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    rdy_in     = 1'b0;
    rw_flag_in = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat [4];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (2) @(negedge clk_in);
    chk8("rst_data_out", data_out, 8'h00);
    chk8("rst_tx_data", tx_data, 8'h00);
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk1("rst_full", io_buffer_full, 1'b0);
    chk1("rst_ovf", tx_overflow, 1'b0);
    chk1("rst_rx_pop", rx_pop, 1'b0);
    chk1("rst_sim_end", sim_end, 1'b0);
    rst_in = 1'b0;

    req(1'b1, 32'h0000_0100, 8'hA5);
    req(1'b0, 32'h0000_0100, 8'h00);
    chk8("rd_a5", data_out, 8'hA5);

    for (int i = 0; i < 4; i++)
      req(1'b1, 32'h0000_0200 + 32'(i), pat[i]);
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 32'h0000_0200 + 32'(i), 8'h00);
      chk8("stream", data_out, pat[i]);
    end

    req(1'b1, 32'h0002_0300, 8'h5C);
    req(1'b0, 32'h0000_0300, 8'h00);
    chk8("alias", data_out, 8'h5C);

    rdy_in     = 1'b0;
    rw_flag_in = 1'b1;
    addr_in    = 32'h0000_0100;
    data_in    = 8'hFF;
    @(negedge clk_in);
    rw_flag_in = 1'b0;
    addr_in    = 32'h0000_0200;
    @(negedge clk_in);
    chk8("rdy_hold", data_out, 8'h5C);
    req(1'b0, 32'h0000_0100, 8'h00);
    chk8("rdy_no_wr", data_out, 8'hA5);

    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      req(1'b1, 32'h0003_0000, 8'(i));
      if (i == 5) chk1("full_at5", io_buffer_full, 1'b0);
      if (i == 6) chk1("full_at6", io_buffer_full, 1'b1);
      if (i == 8) chk1("ovf_at8", tx_overflow, 1'b0);
    end
    chk1("ovf_at9", tx_overflow, 1'b1);
    chk8("head_01", tx_data, 8'h01);

    tx_ready = 1'b1;
    req(1'b1, 32'h0003_0000, 8'h7E);
    tx_ready = 1'b0;
    chk8("head_02", tx_data, 8'h02);
    chk1("full_pp", io_buffer_full, 1'b1);

    tx_ready = 1'b1;
    idle(7);
    chk8("head_7e", tx_data, 8'h7E);
    idle(1);
    chk1("drained", tx_valid, 1'b0);
    tx_ready = 1'b0;

    rx_valid = 1'b1;
    rx_data  = 8'h41;
    req(1'b0, 32'h0003_0000, 8'h00);
    chk8("rx_41", data_out, 8'h41);
    chk1("rx_pop_hi", rx_pop, 1'b1);
    rx_valid = 1'b0;
    idle(1);
    chk1("rx_pop_lo", rx_pop, 1'b0);
    req(1'b0, 32'h0000_0100, 8'h00);
    req(1'b0, 32'h0003_0000, 8'h00);
    chk8("rx_empty", data_out, 8'h00);
    chk1("rx_no_pop", rx_pop, 1'b0);

    req(1'b0, 32'h0000_0100, 8'h00);
    req(1'b0, 32'h0003_0008, 8'h00);
    chk8("io_other", data_out, 8'h00);
    req(1'b1, 32'h0003_0008, 8'hEE);
    chk1("io_other_wr", tx_valid, 1'b0);

    req(1'b1, 32'h0003_0004, 8'h01);
    chk1("sim_end_wr", sim_end, SE_EN);
    req(1'b0, 32'h0000_0100, 8'h00);
    req(1'b0, 32'h0003_0004, 8'h00);
    chk8("sim_end_rd", data_out, {7'b0, SE_EN});

    for (int i = 0; i < 6; i++)
      req(1'b1, 32'h0003_0000, 8'hC0 + 8'(i));
    chk1("pre_rst_full", io_buffer_full, 1'b1);
    tx_ready = 1'b1;
    idle(1);
    #2 rst_in = 1'b1;
    #1;
    chk1("arst_tx_valid", tx_valid, 1'b0);
    chk1("arst_full", io_buffer_full, 1'b0);
    chk1("arst_ovf", tx_overflow, 1'b0);
    chk1("arst_sim_end", sim_end, 1'b0);
    @(negedge clk_in);
    rst_in   = 1'b0;
    tx_ready = 1'b0;
    idle(2);
    chk1("post_rst_valid", tx_valid, 1'b0);
    req(1'b0, 32'h0000_0100, 8'h00);
    chk8("ram_kept", data_out, 8'hA5);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
